// File: rtl/avr_pkg.sv
// Shared definitions for the AVR data-RAM arbiter: owner encoding, selection
// states and the IO-space address decode.
package avr_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_CPU   = 2'd1,
        SEL_DMA   = 2'd2,
        SEL_FORCE = 2'd3
    } sel_e;

    localparam logic [15:0] IO_TOP_DEFAULT = 16'h0060;

    // Addresses below io_top belong to the peripheral space, not the RAM.
    function automatic logic is_io(input logic [15:0] addr, input logic [15:0] io_top);
        return addr < io_top;
    endfunction

endpackage

// File: rtl/avr_ram_arb_if.sv
// Bundle of CPU data port, secondary (DMA) port and RAM port around the arbiter.
// The arbiter uses the slave view; requesters and the RAM use the master view.
interface avr_ram_arb_if #(
    parameter int RAMBITS = 12
) ();

    logic [15:0]        cpu_addr;
    logic               cpu_wen;
    logic               cpu_ren;
    logic [7:0]         cpu_wdata;
    logic [7:0]         cpu_rdata;
    logic               cpu_wait;

    logic               dma_req;
    logic               dma_we;
    logic [15:0]        dma_addr;
    logic [7:0]         dma_wdata;
    logic               dma_gnt;
    logic               dma_rvalid;
    logic [7:0]         dma_rdata;
    logic               dma_err;

    logic [RAMBITS-1:0] ram_addr;
    logic               ram_wen;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram_rdata;

    modport slave (
        input  cpu_addr, cpu_wen, cpu_ren, cpu_wdata,
        output cpu_rdata, cpu_wait,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output ram_addr, ram_wen, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_addr, cpu_wen, cpu_ren, cpu_wdata,
        input  cpu_rdata, cpu_wait,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  ram_addr, ram_wen, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/avr_arb_starve.sv
// Saturating count of consecutive denied DMA cycles and the sticky starved flag.
module avr_arb_starve #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic deny,
    input  logic gnt,
    input  logic force_gnt,
    output logic at_limit,
    output logic starved
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 8'd0;
            starved <= 1'b0;
        end else begin
            if (gnt || !req) begin
                cnt <= 8'd0;
            end else if (deny && (cnt != LIMIT)) begin
                cnt <= cnt + 8'd1;
            end
            if (force_gnt) begin
                starved <= 1'b1;
            end
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/avr_ram_arb.sv
// Shares the single-port data RAM between the CPU (fixed priority) and a
// secondary master whose wait is bounded by the starvation counter.
module avr_ram_arb
    import avr_pkg::*;
#(
    parameter int          RAMBITS      = 12,
    parameter logic [15:0] IO_TOP       = IO_TOP_DEFAULT,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    avr_ram_arb_if.slave bus,
    output logic         starved
);

    logic   cpu_acc;
    logic   dma_io;
    logic   dma_legal;
    logic   at_limit;
    logic   dma_own;
    logic   deny;
    logic   force_sel;
    sel_e   sel;
    owner_e rd_owner;

    always_comb begin
        cpu_acc   = bus.cpu_wen | bus.cpu_ren;
        dma_io    = bus.dma_req & is_io(bus.dma_addr, IO_TOP);
        dma_legal = bus.dma_req & ~is_io(bus.dma_addr, IO_TOP);
    end

    // Owner selection: a saturated counter beats the CPU, otherwise the CPU wins.
    always_comb begin
        sel = SEL_IDLE;
        if (dma_legal && at_limit) begin
            sel = SEL_FORCE;
        end else if (cpu_acc) begin
            sel = SEL_CPU;
        end else if (dma_legal) begin
            sel = SEL_DMA;
        end
    end

    always_comb begin
        force_sel     = (sel == SEL_FORCE);
        dma_own       = (sel == SEL_DMA) || force_sel;
        deny          = (sel == SEL_CPU) && dma_legal;
        bus.dma_gnt   = dma_io | dma_own;
        bus.dma_err   = dma_io;
        bus.cpu_wait  = force_sel;
        if (dma_own) begin
            bus.ram_addr  = bus.dma_addr[RAMBITS-1:0];
            bus.ram_wen   = bus.dma_we;
            bus.ram_wdata = bus.dma_wdata;
        end else begin
            bus.ram_addr  = bus.cpu_addr[RAMBITS-1:0];
            bus.ram_wen   = bus.cpu_wen & ~force_sel;
            bus.ram_wdata = bus.cpu_wdata;
        end
    end

    avr_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.dma_req),
        .deny      (deny),
        .gnt       (bus.dma_gnt),
        .force_gnt (force_sel),
        .at_limit  (at_limit),
        .starved   (starved)
    );

    // Remembers whether this cycle's RAM read belongs to the DMA; the RAM
    // returns the data one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_CPU;
        end else if (dma_own && !bus.dma_we) begin
            rd_owner <= OWN_DMA;
        end else begin
            rd_owner <= OWN_CPU;
        end
    end

    always_comb begin
        bus.dma_rvalid = (rd_owner == OWN_DMA);
        bus.dma_rdata  = bus.dma_rvalid ? bus.ram_rdata : 8'h00;
        bus.cpu_rdata  = bus.ram_rdata;
    end

endmodule

// File: tb/tb_avr_ram_arb.sv
// Directed bench for avr_ram_arb with a cycle-level behavioural model and RAM.
module tb_avr_ram_arb;
    import avr_pkg::*;

    localparam int          RB  = 12;
    localparam int          LIM = 3;
    localparam logic [15:0] IOT = 16'h0060;

    logic clk = 1'b0;
    logic reset;
    logic starved;

    int n_chk  = 0;
    int n_fail = 0;

    avr_ram_arb_if #(.RAMBITS(RB)) bus ();

    avr_ram_arb #(
        .RAMBITS      (RB),
        .IO_TOP       (IOT),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .starved (starved)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write.
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.ram_wen) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: waited = consecutive denied cycles of the current request.
    logic [7:0]  mem_m [0:4095];
    int          waited  = 0;
    bit          rd_pend = 0;
    logic [7:0]  rd_exp  = 8'h00;
    logic [7:0]  ramrd_exp = 8'h00;
    bit          rd_known = 0;
    bit          st_m = 0;
    bit          live = 0;
    bit          m_req = 0, m_legal = 0, m_cpu = 0, m_forced = 0, m_own = 0, m_gnt = 0, m_wen = 0;
    logic [11:0] m_addr = 12'h000;
    logic [7:0]  m_wd = 8'h00;
    logic        m_we = 1'b0;

    always @(negedge clk) begin
        if (live) begin
            if (reset) begin
                waited  = 0;
                rd_pend = 0;
                st_m    = 0;
            end
            m_req    = bus.dma_req;
            m_legal  = bus.dma_req && (bus.dma_addr >= IOT);
            m_cpu    = bus.cpu_wen || bus.cpu_ren;
            m_forced = m_legal && (waited == LIM);
            m_own    = m_legal && (m_forced || !m_cpu);
            m_gnt    = (bus.dma_req && !m_legal) || m_own;
            m_we     = bus.dma_we;
            m_addr   = m_own ? bus.dma_addr[11:0] : bus.cpu_addr[11:0];
            m_wd     = m_own ? bus.dma_wdata : bus.cpu_wdata;
            m_wen    = m_own ? bus.dma_we : (bus.cpu_wen && !m_forced);
            chk("m_gnt", bus.dma_gnt, m_gnt);
            chk("m_err", bus.dma_err, bus.dma_req && !m_legal);
            chk("m_wait", bus.cpu_wait, m_forced);
            chk("m_ram_addr", bus.ram_addr, m_addr);
            chk("m_ram_wen", bus.ram_wen, m_wen);
            if (m_wen) chk("m_ram_wdata", bus.ram_wdata, m_wd);
            chk("m_rvalid", bus.dma_rvalid, rd_pend);
            chk("m_rdata", bus.dma_rdata, rd_pend ? rd_exp : 8'h00);
            chk("m_starved", starved, st_m);
            if (rd_known) chk("m_cpu_rdata", bus.cpu_rdata, ramrd_exp);
        end
    end

    always @(posedge clk) begin
        if (live) begin
            ramrd_exp = mem_m[m_addr];
            rd_known  = 1;
            if (m_wen) mem_m[m_addr] = m_wd;
            if (reset) begin
                waited  = 0;
                rd_pend = 0;
                st_m    = 0;
            end else begin
                rd_pend = m_own && !m_we;
                rd_exp  = ramrd_exp;
                if (m_gnt || !m_req) waited = 0;
                else if (m_legal && m_cpu && waited < LIM) waited++;
                if (m_forced) st_m = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wen   = 1'b0;
        bus.cpu_ren   = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 16'h0000;
        bus.dma_wdata = 8'h00;
    endtask

    logic [7:0] b2b [0:3];

    initial begin
        reset = 1'b1;
        quiet();
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = 8'h00;
            mem_m[i] = 8'h00;
        end
        ram[12'h100] = 8'hA5; mem_m[12'h100] = 8'hA5;
        ram[12'h101] = 8'h3C; mem_m[12'h101] = 8'h3C;
        b2b[0] = 8'h10; b2b[1] = 8'h21; b2b[2] = 8'h32; b2b[3] = 8'h43;
        for (int k = 0; k < 4; k++) begin
            ram[12'h400 + 12'(k)]   = b2b[k];
            mem_m[12'h400 + 12'(k)] = b2b[k];
        end
        live = 1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", bus.dma_gnt, 1'b0);
        chk("rst_rvalid", bus.dma_rvalid, 1'b0);
        chk("rst_rdata", bus.dma_rdata, 8'h00);
        chk("rst_err", bus.dma_err, 1'b0);
        chk("rst_wait", bus.cpu_wait, 1'b0);
        chk("rst_wen", bus.ram_wen, 1'b0);
        chk("rst_starved", starved, 1'b0);
        cyc();
        reset = 1'b0;

        // Single DMA read on an idle CPU
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0100;
        @(negedge clk);
        chk("t1_gnt", bus.dma_gnt, 1'b1);
        chk("t1_wait", bus.cpu_wait, 1'b0);
        cyc();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", bus.dma_rvalid, 1'b1);
        chk("t1_rdata", bus.dma_rdata, 8'hA5);

        // Starvation: CPU writes every cycle, DMA write forced in 4th cycle
        cyc();
        bus.cpu_wen = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h77;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_denied_gnt", bus.dma_gnt, 1'b0);
            chk("t2_denied_wait", bus.cpu_wait, 1'b0);
            cyc();
        end
        @(negedge clk);
        chk("t2_force_wait", bus.cpu_wait, 1'b1);
        chk("t2_force_gnt", bus.dma_gnt, 1'b1);
        chk("t2_force_wen", bus.ram_wen, 1'b1);
        chk("t2_force_addr", bus.ram_addr, 12'h300);
        cyc();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t2_ram300", ram[12'h300], 8'h5A);
        chk("t2_starved", starved, 1'b1);
        chk("t2_cpu_retry_addr", bus.ram_addr, 12'h200);
        chk("t2_cpu_retry_wait", bus.cpu_wait, 1'b0);
        cyc();
        quiet();

        // IO-space DMA request is rejected
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0040;
        @(negedge clk);
        chk("t3_gnt", bus.dma_gnt, 1'b1);
        chk("t3_err", bus.dma_err, 1'b1);
        chk("t3_wen", bus.ram_wen, 1'b0);
        cyc();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t3_no_rvalid", bus.dma_rvalid, 1'b0);
        chk("t3_err_pulse", bus.dma_err, 1'b0);

        // Simultaneous CPU read and DMA read: CPU first
        cyc();
        bus.cpu_ren = 1'b1; bus.cpu_addr = 16'h0100;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0101;
        @(negedge clk);
        chk("t4_cpu_first_gnt", bus.dma_gnt, 1'b0);
        chk("t4_cpu_first_addr", bus.ram_addr, 12'h100);
        cyc();
        bus.cpu_ren = 1'b0;
        @(negedge clk);
        chk("t4_cpu_rdata", bus.cpu_rdata, 8'hA5);
        chk("t4_dma_gnt", bus.dma_gnt, 1'b1);
        chk("t4_dma_addr", bus.ram_addr, 12'h101);
        cyc();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t4_rvalid", bus.dma_rvalid, 1'b1);
        chk("t4_rdata", bus.dma_rdata, 8'h3C);

        // Back-to-back DMA reads 0x400..0x403
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.dma_addr = 16'h0400 + 16'(k);
            @(negedge clk);
            chk("t5_gnt", bus.dma_gnt, 1'b1);
            if (k > 0) begin
                chk("t5_rvalid", bus.dma_rvalid, 1'b1);
                chk("t5_rdata", bus.dma_rdata, b2b[k-1]);
            end
            cyc();
        end
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t5_last_rvalid", bus.dma_rvalid, 1'b1);
        chk("t5_last_rdata", bus.dma_rdata, b2b[3]);

        // Reset in the cycle after a DMA read grant
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0100;
        @(negedge clk);
        chk("t6_gnt", bus.dma_gnt, 1'b1);
        cyc();
        bus.dma_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_rvalid", bus.dma_rvalid, 1'b0);
        chk("t6_rst_starved", starved, 1'b0);
        chk("t6_rst_rdata", bus.dma_rdata, 8'h00);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_rvalid", bus.dma_rvalid, 1'b0);
        chk("t6_post_starved", starved, 1'b0);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avr_ram_arb.md
# avr_ram_arb

Two-requester arbiter for the single-port synchronous data RAM in the AVR SoC. It shares the RAM between the CPU data port and a secondary bus master (DMA or debug engine), and returns read data to whichever requester owned the access. The CPU has fixed priority, and a starvation counter bounds how long the secondary master can be held off. The block sits between `avr_cpu`, the secondary master and the `ram[]` array, replacing the direct CPU-to-RAM connection; IO-mapped peripheral decode stays in the SoC.

## Interface
- `RAMBITS`, default 12: RAM address width; the RAM holds 2^RAMBITS bytes.
- `IO_TOP`, default 16'h0060: data addresses below this value are IO space and cannot be reached by the DMA port.
- `STARVE_LIMIT`, default 8: number of consecutive denied DMA request cycles before an access is forced; legal range 1..255.

Ports (clock and reset first):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_addr` in 16: CPU data address.
- `cpu_wen` in 1: CPU write strobe.
- `cpu_ren` in 1: CPU read strobe.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: read data to the CPU.
- `cpu_wait` out 1: CPU must hold its address, strobes and write data this cycle and retry next cycle.
- `dma_req` in 1: DMA access request; held until `dma_gnt`.
- `dma_we` in 1: 1 = write, 0 = read; stable while `dma_req` is high.
- `dma_addr` in 16: DMA address; stable while `dma_req` is high.
- `dma_wdata` in 8: DMA write data.
- `dma_gnt` out 1: access accepted this cycle; the request is consumed.
- `dma_rvalid` out 1: `dma_rdata` is valid (one cycle after a granted read).
- `dma_rdata` out 8: read data to the DMA.
- `dma_err` out 1: request rejected (IO-space address); one-cycle pulse, coincident with `dma_gnt`.
- `ram_addr` out RAMBITS: RAM address.
- `ram_wen` out 1: RAM write enable.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM registered read data (address in cycle N, data in cycle N+1).
- `starved` out 1: sticky status bit; set when a forced grant occurs, cleared only by reset.

## Operation
- A CPU access is `cpu_wen | cpu_ren`. A DMA access is legal when `dma_req` is high and `dma_addr >= IO_TOP`.
- Illegal DMA request: `dma_gnt` and `dma_err` pulse in the same cycle with no RAM access. The CPU is never affected.
- Per-cycle owner selection:
  - FORCE: starvation count equals `STARVE_LIMIT` and the DMA request is legal. The DMA owns the RAM and `cpu_wait` = 1.
  - CPU: a CPU access is present. The CPU owns the RAM; a legal DMA request is denied and the counter increments.
  - DMA: the DMA request is legal and no CPU access is present. The DMA owns the RAM.
  - IDLE: otherwise. `ram_addr` follows `cpu_addr` and `ram_wen` = 0.
- Starvation counter (8-bit): increments on every denied legal DMA cycle and saturates at `STARVE_LIMIT`. It clears on any `dma_gnt`, and also when `dma_req` is low.
- Once set by a forced grant, `starved` stays set until reset.
- RAM mux:
  - `ram_addr` = owner address[RAMBITS-1:0].
  - `ram_wen` = owner write strobe, gated off when `cpu_wait` = 1.
  - `ram_wdata` = owner write data.
- Read return: a 1-bit owner register records whether the DMA performed a read in cycle N. In cycle N+1, `dma_rvalid` = 1 and `dma_rdata` = `ram_rdata`. `cpu_rdata` = `ram_rdata` unconditionally; the CPU consumes it only after its own granted reads.
- The CPU has priority in every case except FORCE. Two forced grants are never back-to-back, because the counter clears on grant.

## Timing
- Reset values:
  - `dma_gnt`, `dma_rvalid`, `dma_err`, `cpu_wait`, `ram_wen`, `starved` = 0.
  - `dma_rdata` = 0; counter = 0; owner register = CPU.
- `dma_gnt`, `dma_err`, `cpu_wait`, `ram_addr`, `ram_wen` and `ram_wdata` are combinational from the current inputs and registered state.
- `dma_rvalid` and `dma_rdata` are registered outputs.
- DMA read latency: grant in cycle N, `dma_rvalid` in cycle N+1. DMA write: RAM is written at the edge that ends the grant cycle.
- Minimum DMA turnaround is one access per cycle on an idle CPU bus.
- Maximum DMA wait for a legal request is `STARVE_LIMIT` + 1 cycles.
- If reset asserts while a DMA read is outstanding, the pending `dma_rvalid` is dropped. The DMA must re-issue after reset.

## Structure
- Shared package `avr_pkg`:
  - owner encoding `OWN_CPU`/`OWN_DMA`;
  - `IO_TOP` default;
  - a function that decodes an address as IO space.
- One natural sub-module, `avr_arb_starve`: the saturating starvation counter plus the sticky `starved` flag. All other logic stays in the top level.

## Test plan
- CPU idle; DMA reads 0x0100, which holds 0xA5: `dma_gnt` in cycle N; `dma_rvalid` = 1 with `dma_rdata` = 0xA5 in N+1; `cpu_wait` stays 0.
- CPU writes 0x0200 every cycle; DMA writes 0x0300 = 0x5A with `STARVE_LIMIT` = 3: 3 denied cycles; in the 4th cycle `cpu_wait` = 1 and `dma_gnt` = 1; RAM[0x300] = 0x5A; RAM[0x200] is not written in that cycle; `starved` = 1.
- DMA reads 0x0040: `dma_gnt` = `dma_err` = 1 in one cycle; `ram_wen` = 0; no `dma_rvalid` follows.
- Same-cycle CPU read of 0x0100 and DMA read of 0x0101: CPU wins; `cpu_rdata` carries RAM[0x100] in the next cycle; DMA is granted in the first CPU-idle cycle; `dma_rdata` = RAM[0x101].
- Back-to-back DMA reads of 0x0400–0x0403 on an idle CPU: 4 grants in 4 consecutive cycles; 4 `dma_rvalid` pulses offset by one cycle, with the data in address order.
- Assert reset in the cycle after a DMA read grant: `dma_rvalid` = 0, counter = 0, `starved` = 0 while reset is high and in the first cycle after release.
